uart_alu_ctrl: RTL
==================

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 Parameter NB_DATA, default 8: width of UART bytes, operands and result.
REQ-002 Parameter NB_OP, default 6: width of the ALU opcode, taken from the opcode byte LSBs.
REQ-003 Parameter TIMEOUT_CYC, default 5_000_000: maximum i_clk cycles allowed between bytes of one frame; 0 disables the timeout.
REQ-004 i_clk  in  1  system clock, all state on rising edge.
REQ-005 i_reset  in  1  reset, asynchronous, active-high.
REQ-006 i_rx_done_tick  in  1  one-cycle pulse, received byte valid on i_rx_data.
REQ-007 i_rx_data  in  NB_DATA  received byte.
REQ-008 i_alu_result  in  NB_DATA  combinational ALU result of o_alu_a, o_alu_b, o_alu_op.
REQ-009 i_tx_done_tick  in  1  one-cycle pulse, transmitter finished the byte.
REQ-010 o_alu_a, o_alu_b  out  NB_DATA each  registered operands.
REQ-011 o_alu_op  out  NB_OP  registered opcode.
REQ-012 o_tx_start  out  1  one-cycle transmit request.
REQ-013 o_tx_data  out  NB_DATA  registered byte to transmit.
REQ-014 o_busy  out  1  high in SEND, START_TX and WAIT_TX.
REQ-015 o_timeout  out  1  one-cycle pulse on frame abort.
REQ-016 o_overrun  out  1  sticky flag, byte dropped while busy.

Function
REQ-017 The FSM SHALL have one-hot states WAIT_A, WAIT_B, WAIT_OP, SEND, START_TX, WAIT_TX; an illegal encoding SHALL return to WAIT_A on the next edge.
REQ-018 WAIT_A + i_rx_done_tick: load o_alu_a <= i_rx_data, clear timeout counter, go to WAIT_B.
REQ-019 WAIT_B + i_rx_done_tick: load o_alu_b, clear counter, go to WAIT_OP.
REQ-020 WAIT_OP + i_rx_done_tick: load o_alu_op <= i_rx_data[NB_OP-1:0] (upper bits ignored), go to SEND.
REQ-021 SEND SHALL last exactly one cycle: load o_tx_data <= i_alu_result, go to START_TX.
REQ-022 START_TX SHALL last exactly one cycle with o_tx_start=1, then go to WAIT_TX; o_tx_start SHALL be 0 in every other state.
REQ-023 WAIT_TX + i_tx_done_tick: go to WAIT_A; o_tx_data SHALL hold its value until the next SEND.
REQ-024 Latency: opcode rx_done in cycle N gives o_tx_start high in cycle N+2, exactly once per frame.
REQ-025 Timeout counter SHALL increment each cycle in WAIT_B and WAIT_OP only, and hold at 0 elsewhere.
REQ-026 When the counter equals TIMEOUT_CYC-1 with no rx_done that cycle, the FSM SHALL go to WAIT_A, pulse o_timeout for one cycle and clear the counter; operand registers keep their values.
REQ-027 Simultaneous rx_done and terminal count: the byte SHALL win; it is accepted per REQ-019/020 and no timeout is issued.
REQ-028 TIMEOUT_CYC=0: the counter SHALL never trigger.
REQ-029 i_rx_done_tick in SEND, START_TX or WAIT_TX: the byte SHALL be dropped, registers unchanged, o_overrun set to 1 until reset.
REQ-030 i_tx_done_tick outside WAIT_TX SHALL be ignored.
REQ-031 Counter width SHALL be sufficient for TIMEOUT_CYC-1 without wrap.

Reset
REQ-032 While i_reset=1: state WAIT_A; counter 0; o_alu_a, o_alu_b, o_alu_op, o_tx_data 0; o_tx_start, o_busy, o_timeout, o_overrun 0.
REQ-033 Reset asserted mid-frame or during WAIT_TX SHALL discard the frame; after release the next byte SHALL be treated as operand A.

Verification
REQ-034 Bytes 0x05, 0x03, 0x20, ALU model returns 0x08 -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20, one o_tx_start 2 cycles after the third rx_done, o_tx_data=0x08.
REQ-035 Opcode byte 0xE2 with NB_OP=6 -> o_alu_op=0x22.
REQ-036 TIMEOUT_CYC=100, send 0x11 then idle 100 cycles -> o_timeout pulses once, state WAIT_A; next bytes 0x07, 0x01, 0x20 form a fresh frame.
REQ-037 rx_done on the same cycle the counter reaches 99 -> byte accepted as B, no o_timeout.
REQ-038 Extra byte 0x55 during WAIT_TX -> o_overrun=1 and stays 1; o_tx_data unchanged; next frame after tx_done is processed normally.
REQ-039 Reset pulse after bytes A and B -> all outputs 0; the following 3 bytes produce one correct result.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - UART-fed ALU frame controller: collects A, B, opcode bytes and transmits the result.
module uart_alu_ctrl #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [5:0] {
    WAIT_A   = 6'b000001,
    WAIT_B   = 6'b000010,
    WAIT_OP  = 6'b000100,
    SEND     = 6'b001000,
    START_TX = 6'b010000,
    WAIT_TX  = 6'b100000
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             in_frame;
  logic             timeout_hit;

  assign in_frame = (state_q == WAIT_B) || (state_q == WAIT_OP);
  // A byte arriving on the terminal count wins over the abort.
  assign timeout_hit = TIMEOUT_EN && in_frame && !i_rx_done_tick && (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= WAIT_A;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A:   if (i_rx_done_tick) state_d = WAIT_B;
      WAIT_B: begin
        if (i_rx_done_tick)   state_d = WAIT_OP;
        else if (timeout_hit) state_d = WAIT_A;
      end
      WAIT_OP: begin
        if (i_rx_done_tick)   state_d = SEND;
        else if (timeout_hit) state_d = WAIT_A;
      end
      SEND:     state_d = START_TX;
      START_TX: state_d = WAIT_TX;
      WAIT_TX:  if (i_tx_done_tick) state_d = WAIT_A;
      default:  state_d = WAIT_A;
    endcase
  end

  always_comb begin
    o_busy     = 1'b0;
    o_tx_start = 1'b0;
    case (state_q)
      SEND, WAIT_TX: o_busy = 1'b1;
      START_TX: begin
        o_busy     = 1'b1;
        o_tx_start = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;
      cnt_q     <= '0;
    end else begin
      o_timeout <= timeout_hit;
      if (state_q == WAIT_A && i_rx_done_tick)  o_alu_a  <= i_rx_data;
      if (state_q == WAIT_B && i_rx_done_tick)  o_alu_b  <= i_rx_data;
      if (state_q == WAIT_OP && i_rx_done_tick) o_alu_op <= i_rx_data[NB_OP-1:0];
      if (state_q == SEND)                      o_tx_data <= i_alu_result;
      if (o_busy && i_rx_done_tick)             o_overrun <= 1'b1;
      if (TIMEOUT_EN && in_frame && !i_rx_done_tick && !timeout_hit)
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;
    end
  end

endmodule
